seq_detect_param: RTL
=====================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL provide parameter PAT_W, default 12, pattern length in bits (legal 2..32).
REQ-002 SHALL provide parameter CNT_W, default 8, width of the match counter (legal 1..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port clr_i  input  1  synchronous soft clear of all detection state.
REQ-006 SHALL have port x_i  input  1  serial data bit.
REQ-007 SHALL have port valid_i  input  1  x_i is sampled only in cycles where valid_i=1.
REQ-008 SHALL have port pattern_i  input  PAT_W  target sequence; bit PAT_W-1 = oldest (first received) bit.
REQ-009 SHALL have port mask_i  input  PAT_W  per-bit compare enable (1=compare, 0=don't care).
REQ-010 SHALL have port overlap_i  input  1  1=overlapping detection, 0=non-overlapping.
REQ-011 SHALL have port det_o  output  1  one-cycle detection pulse, registered.
REQ-012 SHALL have port count_o  output  CNT_W  saturating count of detections, registered.

Function
REQ-013 SHALL hold a PAT_W-bit shift register; on each valid sample, next = {shift[PAT_W-2:0], x_i}; no shift when valid_i=0.
REQ-014 SHALL hold a fill counter (0..PAT_W, saturating at PAT_W) counting valid samples since reset, clr_i, or the last non-overlapping detection.
REQ-015 SHALL define match as ((next_shift XOR pattern_i) AND mask_i) == 0, using the post-shift shift value.
REQ-016 SHALL define a hit as: valid_i=1 AND match AND (fill+1 >= PAT_W, i.e. the sample completes or follows a full window).
REQ-017 SHALL register det_o <= hit; det_o is high exactly in the cycle after the edge that samples the completing bit, and low otherwise.
REQ-018 SHALL never assert det_o in a cycle following valid_i=0, even when match stays true.
REQ-019 SHALL, on a hit with overlap_i=1, keep the fill counter at PAT_W so the next valid sample can hit again.
REQ-020 SHALL, on a hit with overlap_i=0, reset the fill counter to 0 (shift register still updated), so PAT_W further valid samples are needed before the next hit.
REQ-021 SHALL increment count_o by 1 on each hit, saturating at 2^CNT_W-1 (no wrap).
REQ-022 SHALL sample pattern_i, mask_i, overlap_i combinationally at each valid sample; changes affect only samples taken in or after the cycle of the change; no internal copy is kept.
REQ-023 SHALL treat mask_i=0 (all don't-care) as always-match: with overlap_i=1, hit on every valid sample once the window is full.
REQ-024 SHALL, when clr_i=1, on that edge clear shift, fill, det_o, count_o to 0 and ignore x_i/valid_i in that cycle.
REQ-025 SHALL give reset priority over clr_i, and clr_i priority over a simultaneous valid sample.

Reset
REQ-026 SHALL, while reset=1 at a rising edge, set shift=0, fill=0, det_o=0, count_o=0.
REQ-027 SHALL produce no hit from the cleared shift register contents, including when pattern_i=0 (fill gating per REQ-016).
REQ-028 SHALL, when reset is asserted mid-sequence, discard all partially received bits; detection restarts from an empty window.

Verification
REQ-029 SHALL verify basic: PAT_W=12, pattern 12'hEDB, mask 12'hFFF, valid every cycle, stream 1110_1101_1011 -> det_o=1 for exactly one cycle after 12th bit, count_o=1.
REQ-030 SHALL verify overlap: pattern 12'hAAA, stream 10101010101010 (14 bits) -> overlap_i=1: det after bits 12 and 14, count_o=2; overlap_i=0: det only after bit 12, count_o=1.
REQ-031 SHALL verify valid gaps: the 12'hEDB stream with valid_i=0 on random cycles and x_i toggling during gaps -> single det after 12th valid bit, count_o=1.
REQ-032 SHALL verify masking: pattern 12'hEDB, mask 12'hFF0, stream 1110_1101_0110 -> det_o pulse, count_o=1; same stream with mask 12'hFFF -> no det.
REQ-033 SHALL verify saturation: CNT_W=2, mask 0, overlap_i=1, 20 valid bits -> count_o reaches 3 and holds 3; det_o pulses from bit 12 onward.
REQ-034 SHALL verify mid-stream clear: pattern 12'h000, 8 zero bits, clr_i for one cycle, 4 more zero bits -> no det, count_o=0; 8 further zero bits -> det after the 12th post-clear bit. Same with reset in place of clr_i.

Source files
------------

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a per-bit compare mask, overlap control and a
// saturating match counter.
module seq_detect_param #(
  parameter int unsigned PAT_W = 12,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             x_i,
  input  logic             valid_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [PAT_W-1:0] mask_i,
  input  logic             overlap_i,
  output logic             det_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillMax  = FillW'(PAT_W);
  localparam logic [FillW-1:0] FillLast = FillW'(PAT_W - 1);

  logic [PAT_W-1:0] shift_q, shift_d, shift_next;
  logic [FillW-1:0] fill_q, fill_d;
  logic             det_q, det_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             match;
  logic             window_ok;
  logic             hit;

  // Compare against the post-shift window so the completing bit is included.
  assign shift_next = {shift_q[PAT_W-2:0], x_i};
  assign match      = ((shift_next ^ pattern_i) & mask_i) == '0;
  assign window_ok  = fill_q >= FillLast;
  assign hit        = valid_i & match & window_ok;

  always_comb begin
    shift_d = shift_q;
    fill_d  = fill_q;
    det_d   = 1'b0;
    count_d = count_q;
    if (clr_i) begin
      shift_d = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (valid_i) begin
      shift_d = shift_next;
      det_d   = hit;
      if (hit) begin
        // Non-overlapping mode needs a whole fresh window before the next hit.
        fill_d = overlap_i ? FillMax : '0;
        if (count_q != '1) begin
          count_d = count_q + CNT_W'(1);
        end
      end else if (fill_q != FillMax) begin
        fill_d = fill_q + FillW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      fill_q  <= '0;
      det_q   <= 1'b0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      fill_q  <= fill_d;
      det_q   <= det_d;
      count_q <= count_d;
    end
  end

  assign det_o   = det_q;
  assign count_o = count_q;

endmodule
